// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus controller: FSM states,
// access-size encoding, region select codes and region address windows.
package lsu_pkg;

  localparam int ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  localparam logic [1:0] SEL_MEM_LO = 2'b11;
  localparam logic [1:0] SEL_MEM_HI = 2'b10;
  localparam logic [1:0] SEL_PERIPH = 2'b01;
  localparam logic [1:0] SEL_ROM    = 2'b00;

  localparam logic [ADDR_W-1:0] MEM_LO_BASE  = 13'h0000;
  localparam logic [ADDR_W-1:0] MEM_LO_LIMIT = 13'h07FF;
  localparam logic [ADDR_W-1:0] MEM_HI_BASE  = 13'h0800;
  localparam logic [ADDR_W-1:0] MEM_HI_LIMIT = 13'h0FFF;
  localparam logic [ADDR_W-1:0] PERIPH_BASE  = 13'h1C00;
  localparam logic [ADDR_W-1:0] PERIPH_LIMIT = 13'h1C0F;
  localparam logic [ADDR_W-1:0] ROM_BASE     = 13'h1E00;
  localparam logic [ADDR_W-1:0] ROM_LIMIT    = 13'h1E0F;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 4'b0001 << offset;
      SZ_HALF: return 4'b0011 << offset;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0]  size,
                                                 input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_region_dec.sv
// Combinational address decoder: maps an address to a target select and flags
// unmapped addresses and writes to the read-only region.
module lsu_region_dec
  import lsu_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic [1:0]        sel,
  output logic              fault
);

  logic unmapped;

  always_comb begin
    sel      = SEL_MEM_LO;
    unmapped = 1'b0;
    if (in_range(addr, MEM_LO_BASE, MEM_LO_LIMIT)) begin
      sel = SEL_MEM_LO;
    end else if (in_range(addr, MEM_HI_BASE, MEM_HI_LIMIT)) begin
      sel = SEL_MEM_HI;
    end else if (in_range(addr, PERIPH_BASE, PERIPH_LIMIT)) begin
      sel = SEL_PERIPH;
    end else if (in_range(addr, ROM_BASE, ROM_LIMIT)) begin
      sel = SEL_ROM;
    end else begin
      unmapped = 1'b1;
    end
  end

  assign fault = unmapped || (we && (sel == SEL_ROM));

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one outstanding core access to a region-decoded target bus with timeout.
// Optional LSU_ALIGN_CHECK_EN: fault misaligned half/word accesses instead of force-aligning them.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        cap_size;
  logic              cap_unsigned;
  logic              accept;
  logic              timeout_hit;
  logic [ADDR_W-1:0] addr_eff;
  logic              misalign;
  logic [1:0]        dec_sel;
  logic              dec_fault;
  logic              fault;
  logic [31:0]       shifted;
  logic [31:0]       load_data;

  always_comb begin
    addr_eff = req_addr;
    misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
               ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (req_size == SZ_HALF) addr_eff[0]   = 1'b0;
    if (req_size == SZ_WORD) addr_eff[1:0] = 2'b00;
`endif
  end

  lsu_region_dec u_dec (
    .addr  (addr_eff),
    .we    (req_we),
    .sel   (dec_sel),
    .fault (dec_fault)
  );

  assign fault       = dec_fault || (req_size == SZ_ILL) || misalign;
  assign accept      = req_valid && (state == IDLE);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = fault ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_en = 1'b1;
        // An ack in the expiry cycle wins over the timeout.
        if (mem_ack || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction uses the already-aligned captured address.
  always_comb begin
    shifted = mem_rdata >> {mem_addr[1:0], 3'b000};
    case (cap_size)
      SZ_BYTE: load_data = cap_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = cap_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      mem_sel      <= SEL_MEM_LO;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= 4'b0000;
      mem_wdata    <= 32'h0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt          <= '0;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            rsp_rdata    <= 32'h0;
            rsp_err      <= fault;
            if (!fault) begin
              mem_sel   <= dec_sel;
              mem_we    <= req_we;
              mem_addr  <= addr_eff;
              mem_be    <= byte_enables(req_size, addr_eff[1:0]);
              mem_wdata <= lane_replicate(req_size, req_wdata);
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= mem_we ? 32'h0 : load_data;
          end else if (timeout_hit) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed self-checking bench for lsu_bus_ctrl (default TIMEOUT_CYCLES=16).
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [12:0] req_addr = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  mem_sel;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  lsu_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns in the cycle after accept.
  task automatic issue(input logic we, input logic [12:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic ack_now(input logic [31:0] rdata);
    mem_rdata = rdata; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    step(); step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_sel",   32'(mem_sel),   32'd3);
    check("rst_mem_be",    32'(mem_be),    32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'd0);
    rst = 1'b0;
    step();

    // Word read at 0x0004, acked in first ACCESS cycle.
    issue(1'b0, 13'h0004, 2'b10, 1'b0, 32'h0);
    check("w_rd_mem_en",    32'(mem_en),    32'd1);
    check("w_rd_mem_sel",   32'(mem_sel),   32'd3);
    check("w_rd_mem_be",    32'(mem_be),    32'hF);
    check("w_rd_mem_addr",  32'(mem_addr),  32'h0004);
    check("w_rd_req_ready", 32'(req_ready), 32'd0);
    check("w_rd_early_vld", 32'(rsp_valid), 32'd0);
    ack_now(32'hDEADBEEF);
    check("w_rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("w_rd_rdata",     rsp_rdata,      32'hDEADBEEF);
    check("w_rd_err",       32'(rsp_err),   32'd0);
    check("w_rd_en_off",    32'(mem_en),    32'd0);
    finish_rsp();

    // Signed then unsigned byte read at 0x0802.
    issue(1'b0, 13'h0802, 2'b00, 1'b0, 32'h0);
    check("b_rd_mem_sel", 32'(mem_sel), 32'd2);
    check("b_rd_mem_be",  32'(mem_be),  32'b0100);
    ack_now(32'h00800000);
    check("b_rd_signed",  rsp_rdata,    32'hFFFFFF80);
    finish_rsp();
    issue(1'b0, 13'h0802, 2'b00, 1'b1, 32'h0);
    ack_now(32'h00800000);
    check("b_rd_unsigned", rsp_rdata,   32'h00000080);
    finish_rsp();

    // Faults: write to read-only region, unmapped address, illegal size.
    issue(1'b1, 13'h1E04, 2'b10, 1'b0, 32'h11223344);
    check("rom_wr_mem_en", 32'(mem_en),    32'd0);
    check("rom_wr_valid",  32'(rsp_valid), 32'd1);
    check("rom_wr_err",    32'(rsp_err),   32'd1);
    finish_rsp();
    issue(1'b0, 13'h1000, 2'b10, 1'b0, 32'h0);
    check("unmap_mem_en", 32'(mem_en),    32'd0);
    check("unmap_valid",  32'(rsp_valid), 32'd1);
    check("unmap_err",    32'(rsp_err),   32'd1);
    finish_rsp();
    issue(1'b0, 13'h0000, 2'b11, 1'b0, 32'h0);
    check("ill_size_mem_en", 32'(mem_en),  32'd0);
    check("ill_size_err",    32'(rsp_err), 32'd1);
    finish_rsp();
    issue(1'b0, 13'h1E08, 2'b10, 1'b0, 32'h0);
    check("rom_rd_mem_en",  32'(mem_en),  32'd1);
    check("rom_rd_mem_sel", 32'(mem_sel), 32'd0);
    ack_now(32'hCAFEF00D);
    check("rom_rd_err",   32'(rsp_err), 32'd0);
    check("rom_rd_rdata", rsp_rdata,    32'hCAFEF00D);
    finish_rsp();

    // Timeout: no ack for 16 ACCESS cycles.
    issue(1'b0, 13'h1C08, 2'b10, 1'b0, 32'h0);
    check("to_mem_sel", 32'(mem_sel), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("to_mem_en_c%0d", i), 32'(mem_en), 32'd1);
      check($sformatf("to_no_rsp_c%0d", i), 32'(rsp_valid), 32'd0);
      step();
    end
    check("to_mem_en_off", 32'(mem_en),    32'd0);
    check("to_rsp_valid",  32'(rsp_valid), 32'd1);
    check("to_rsp_err",    32'(rsp_err),   32'd1);
    check("to_rsp_rdata",  rsp_rdata,      32'd0);
    finish_rsp();

    // Ack arrives in the 16th (expiry) cycle: success.
    issue(1'b0, 13'h1C08, 2'b10, 1'b0, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("to16_mem_en_c%0d", i), 32'(mem_en), 32'd1);
      if (i == 16) begin mem_ack = 1'b1; mem_rdata = 32'h12345678; end
      step();
    end
    mem_ack = 1'b0;
    check("to16_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to16_rsp_err",   32'(rsp_err),   32'd0);
    check("to16_rsp_rdata", rsp_rdata,      32'h12345678);
    finish_rsp();

    // Half write at misaligned 0x0003.
    issue(1'b1, 13'h0003, 2'b01, 1'b0, 32'h0000ABCD);
`ifdef LSU_ALIGN_CHECK_EN
    check("hw_mis_mem_en", 32'(mem_en),    32'd0);
    check("hw_mis_valid",  32'(rsp_valid), 32'd1);
    check("hw_mis_err",    32'(rsp_err),   32'd1);
`else
    check("hw_mem_en",    32'(mem_en),    32'd1);
    check("hw_mem_we",    32'(mem_we),    32'd1);
    check("hw_mem_addr",  32'(mem_addr),  32'h0002);
    check("hw_mem_be",    32'(mem_be),    32'b1100);
    check("hw_mem_wdata", mem_wdata,      32'hABCDABCD);
    ack_now(32'hFFFFFFFF);
    check("hw_rsp_err",   32'(rsp_err),   32'd0);
    check("hw_rsp_rdata", rsp_rdata,      32'd0);
`endif
    finish_rsp();

    // Byte write lane replication at 0x0801.
    issue(1'b1, 13'h0801, 2'b00, 1'b0, 32'h000000A5);
    check("bw_mem_be",    32'(mem_be), 32'b0010);
    check("bw_mem_wdata", mem_wdata,   32'hA5A5A5A5);
    ack_now(32'h0);
    finish_rsp();

    // Response stall for 5 cycles, with a stray ack that must be ignored.
    issue(1'b0, 13'h0001, 2'b00, 1'b1, 32'h0);
    ack_now(32'h0000AB00);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_valid_%0d", i), 32'(rsp_valid), 32'd1);
      check($sformatf("stall_rdata_%0d", i), rsp_rdata,      32'h000000AB);
      check($sformatf("stall_err_%0d", i),   32'(rsp_err),   32'd0);
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'h55555555; end
      step();
      mem_ack = 1'b0;
    end
    check("stall_rdata_end", rsp_rdata, 32'h000000AB);
    finish_rsp();

    // Reset asserted mid-ACCESS takes effect without waiting for a clock.
    issue(1'b1, 13'h0804, 2'b10, 1'b0, 32'h87654321);
    check("pre_rst_mem_en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_mem_en",    32'(mem_en),    32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_mem_sel",   32'(mem_sel),   32'd3);
    check("arst_mem_we",    32'(mem_we),    32'd0);
    check("arst_mem_addr",  32'(mem_addr),  32'd0);
    check("arst_mem_be",    32'(mem_be),    32'd0);
    check("arst_mem_wdata", mem_wdata,      32'd0);
    check("arst_rsp_err",   32'(rsp_err),   32'd0);
    step();
    rst = 1'b0;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    step();

    issue(1'b0, 13'h0008, 2'b10, 1'b0, 32'h0);
    check("post_rst_mem_en", 32'(mem_en), 32'd1);
    ack_now(32'h0BADF00D);
    check("post_rst_rdata", rsp_rdata, 32'h0BADF00D);
    finish_rsp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of cycles to wait for mem_ack before aborting an access.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have request ports from the core:
- req_valid in 1
- req_ready out 1
- req_we in 1
- req_addr in 13
- req_size in 2: 00 byte, 01 half, 10 word, 11 illegal
- req_unsigned in 1
- req_wdata in 32
REQ-005 SHALL have response ports to the core:
- rsp_valid out 1
- rsp_ready in 1
- rsp_rdata out 32
- rsp_err out 1
REQ-006 SHALL have target-side ports:
- mem_sel out 2
- mem_en out 1
- mem_we out 1
- mem_addr out 13
- mem_be out 4
- mem_wdata out 32
- mem_rdata in 32
- mem_ack in 1

Function
REQ-007 SHALL implement an FSM with states IDLE, ACCESS and RESP; req_ready=1 only in IDLE.
REQ-008 SHALL capture the request (addr, size, we, unsigned, wdata) when req_valid and req_ready are both 1.
REQ-009 SHALL decode the captured address into regions as follows; any other address is unmapped:
- 0x0000-0x07FF: mem_sel=11
- 0x0800-0x0FFF: mem_sel=10
- 0x1C00-0x1C0F: mem_sel=01
- 0x1E00-0x1E0F: mem_sel=00
REQ-010 SHALL raise a fault for any of: an unmapped address, req_size=11, or a write to region 00 (read-only).
REQ-011 SHALL, on accept, go IDLE->RESP with rsp_err=1 when a fault is raised; mem_en never asserts for a faulting access.
REQ-012 SHALL, on accept without a fault, go IDLE->ACCESS.
REQ-013 SHALL, in ACCESS, hold mem_en=1 and keep mem_sel, mem_we, mem_addr, mem_be and mem_wdata stable until mem_ack.
REQ-014 SHALL drive mem_be as follows:
- byte access: 1<<addr[1:0]
- half access: 0011<<addr[1:0]
- word access: 1111
REQ-015 SHALL drive mem_wdata as req_wdata replicated across byte lanes (byte x4, half x2).
REQ-016 SHALL, on mem_ack in ACCESS, move to RESP; for a read, rsp_rdata = mem_rdata shifted right by 8*addr[1:0], then sign-extended to 32 bits (zero-extended if req_unsigned); for a write, rsp_rdata=0.
REQ-017 SHALL count ACCESS cycles; if mem_ack has not arrived after TIMEOUT_CYCLES cycles, deassert mem_en and move to RESP with rsp_err=1.
REQ-018 SHALL treat mem_ack arriving in the same cycle as the timeout expiry as success.
REQ-019 SHALL hold rsp_valid=1 in RESP until rsp_ready; RESP->IDLE on rsp_ready.
REQ-020 SHALL hold rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL ignore mem_ack outside ACCESS.
REQ-022 SHALL give a minimum latency, accept to rsp_valid, of 1 cycle for a fault and 2 cycles for an access acknowledged in its first ACCESS cycle.

Reset
REQ-023 SHALL, on rst, go immediately to IDLE, including mid-ACCESS or mid-RESP, and drive these values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_be=0, mem_sel=11, mem_addr=0, mem_wdata=0; the timeout counter is cleared.

Configuration
REQ-024 SHALL, with LSU_ALIGN_CHECK_EN defined, fault a half access with addr[0]=1 or a word access with addr[1:0]!=0 (a misaligned access) per REQ-011.
REQ-025 SHALL, without LSU_ALIGN_CHECK_EN, force the address to alignment instead of faulting: addr[0]=0 for half accesses, addr[1:0]=0 for word accesses, with no error.

Structure
REQ-026 SHALL place the state enum, size encoding, region sel constants and region base/limit constants in shared package lsu_pkg.
REQ-027 SHALL implement address decode in combinational sub-module lsu_region_dec (input addr and we; outputs sel and fault).

Verification
REQ-028 SHALL have the bench cover word read at 0x0004, mem_ack on the first ACCESS cycle, mem_rdata=0xDEADBEEF -> mem_sel=11, mem_be=1111, rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-029 SHALL have the bench cover signed byte read at 0x0802, mem_rdata=0x00800000 -> mem_sel=10, mem_be=0100, rsp_rdata=0xFFFFFF80; the same read with req_unsigned=1 -> rsp_rdata=0x00000080.
REQ-030 SHALL have the bench cover write to 0x1E04 and an access to 0x1000 -> no mem_en, rsp_err=1 one cycle after accept.
REQ-031 SHALL have the bench cover read at 0x1C08 with mem_ack never asserted -> mem_en held 16 cycles, then rsp_err=1; a repeat with mem_ack on cycle 16 -> rsp_err=0.
REQ-032 SHALL have the bench cover half write at 0x0003, run with and without LSU_ALIGN_CHECK_EN -> with the macro: rsp_err=1, no mem_en; without it: mem_addr=0x0002, mem_be=1100.
REQ-033 SHALL have the bench cover rst asserted mid-ACCESS, and rsp_ready held 0 for 5 cycles in RESP -> reset outputs immediately, req_ready=1 next cycle; the response stays stable until rsp_ready.
